f1_start_sequencer: RTL

//  Race-start controller for the F1 lights board. On a trigger it lights the 8 start

---
 rtl/f1_start_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/f1_start_sequencer.sv
// F1 start-lights sequencer: lamp countdown, random hold, reaction-time measurement.
// Optional macro F1_REACT_SYNC_EN: synchronise the react button and act on its rising edge only.
module f1_start_sequencer #(
    parameter int TICK_DIV = 24,
    parameter int RT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            react,
    output logic [7:0]      lights,
    output logic            light_step,
    output logic [RT_W-1:0] react_time,
    output logic            rt_valid,
    output logic            jump_start
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEQ, S_HOLD, S_GO, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      lights_q, lights_d;
    logic            step_q, step_d;
    logic [RT_W-1:0] react_time_q, react_time_d;
    logic            rt_valid_q, rt_valid_d;
    logic            jump_q, jump_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [6:0]      lfsr_q, lfsr_d;
    logic [6:0]      hold_q, hold_d;
    logic [RT_W-1:0] rt_cnt_q, rt_cnt_d;
    logic            react_eff;
    logic            tick;

`ifdef F1_REACT_SYNC_EN
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= react;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign react_eff = sync2_q & ~prev_q;
`else
    assign react_eff = react;
`endif

    assign tick = ((state_q == S_SEQ) || (state_q == S_HOLD)) && (presc_q == '0);

    always_comb begin
        state_d      = state_q;
        lights_d     = lights_q;
        step_d       = 1'b0;
        react_time_d = react_time_q;
        rt_valid_d   = rt_valid_q;
        jump_d       = jump_q;
        presc_d      = presc_q;
        hold_d       = hold_q;
        rt_cnt_d     = rt_cnt_q;
        lfsr_d       = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

        if ((state_q == S_SEQ) || (state_q == S_HOLD)) begin
            presc_d = tick ? PRE_RELOAD : presc_q - 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (trigger) begin
                    state_d    = S_SEQ;
                    lights_d   = 8'h00;
                    rt_valid_d = 1'b0;
                    jump_d     = 1'b0;
                    presc_d    = PRE_RELOAD;
                end
            end
            S_SEQ, S_HOLD: begin
                // A press before lights-out beats any coincident tick
                if (react_eff) begin
                    state_d      = S_DONE;
                    lights_d     = 8'h00;
                    jump_d       = 1'b1;
                    rt_valid_d   = 1'b0;
                    react_time_d = '0;
                end else if (tick && (state_q == S_SEQ)) begin
                    lights_d = {lights_q[6:0], 1'b1};
                    step_d   = 1'b1;
                    if (lights_q[6:0] == 7'h7F) begin
                        state_d = S_HOLD;
                        hold_d  = lfsr_q;
                    end
                end else if (tick) begin
                    if (hold_q == 7'd1) begin
                        state_d  = S_GO;
                        lights_d = 8'h00;
                        step_d   = 1'b1;
                        rt_cnt_d = '0;
                    end else begin
                        hold_d = hold_q - 7'd1;
                    end
                end
            end
            S_GO: begin
                if (react_eff) begin
                    state_d      = S_DONE;
                    react_time_d = rt_cnt_q;
                    rt_valid_d   = 1'b1;
                end else if (rt_cnt_q != {RT_W{1'b1}}) begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lights_q     <= 8'h00;
            step_q       <= 1'b0;
            react_time_q <= '0;
            rt_valid_q   <= 1'b0;
            jump_q       <= 1'b0;
            presc_q      <= PRE_RELOAD;
            lfsr_q       <= 7'h01;
            hold_q       <= 7'd0;
            rt_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            lights_q     <= lights_d;
            step_q       <= step_d;
            react_time_q <= react_time_d;
            rt_valid_q   <= rt_valid_d;
            jump_q       <= jump_d;
            presc_q      <= presc_d;
            lfsr_q       <= lfsr_d;
            hold_q       <= hold_d;
            rt_cnt_q     <= rt_cnt_d;
        end
    end

    assign lights     = lights_q;
    assign light_step = step_q;
    assign react_time = react_time_q;
    assign rt_valid   = rt_valid_q;
    assign jump_start = jump_q;
endmodule
